// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive word buffer.
//   WORD_BYTES  : bytes packed into one output word
//   byte_t      : one received byte
//   word_t      : one assembled word
//   asm_state_t : word assembler state (FILL collects bytes, HOLD presents a word)
package uart_pkg;

  localparam int WORD_BYTES = 4;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } asm_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO with first-word fall-through read port.
//   clk, rstn        : clock, asynchronous active-low reset
//   flush            : synchronous empty (pointers and count to 0), wins over wr/rd
//   wr_en, wr_data   : write one byte; ignored when full
//   full             : count == 2**DEPTH_LOG2
//   rd_en            : pop the head byte; ignored when empty
//   rd_data          : head byte, combinational from the array
//   empty            : count == 0
//   count            : bytes currently stored (DEPTH_LOG2+1 bits)
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  output logic                full,
  input  logic                rd_en,
  output logic [7:0]          rd_data,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  byte_t                 r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_do_wr;
  logic                  w_do_rd;

  // Full/empty come from the registered count, so a same-cycle pop never
  // frees a slot for a same-cycle write.
  assign full    = (r_count == FULL_CNT);
  assign empty   = (r_count == '0);
  assign w_do_wr = wr_en & ~full & ~flush;
  assign w_do_rd = rd_en & ~empty & ~flush;
  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;

  // Storage array carries no reset; stale contents are never read because
  // the count gates every read.
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_word_buf.sv
// Receive-side buffer behind the UART receiver: qualifies byte strobes,
// queues them in a byte FIFO, packs them into 32-bit words and hands the
// words to the core over valid/ready. Framing errors and overflows are
// latched in sticky flags.
//   clk, rstn            : clock, asynchronous active-low reset
//   rx_data, rx_valid    : received byte and its one-cycle strobe
//   rx_ferr              : framing error for the same-cycle strobe
//   clr                  : synchronous flush of FIFO, partial word and flags
//   word_data, word_valid: assembled word and its valid (held until ready)
//   word_ready           : core accepts the word
//   fifo_count           : bytes in the FIFO
//   byte_cnt             : bytes in the partial word (0..3)
//   overflow, ferr_seen  : sticky error flags
module uart_rx_word_buf
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  input  logic                rx_ferr,
  input  logic                clr,
  output logic [31:0]         word_data,
  output logic                word_valid,
  input  logic                word_ready,
  output logic [DEPTH_LOG2:0] fifo_count,
  output logic [1:0]          byte_cnt,
  output logic                overflow,
  output logic                ferr_seen
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  asm_state_t r_state;
  asm_state_t w_state_nxt;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_nxt;
  word_t      r_word;
  word_t      w_word_nxt;
  logic       r_overflow;
  logic       r_ferr_seen;
  logic       w_pop;
  logic       w_wr_en;
  logic       w_full;
  logic       w_empty;
  byte_t      w_rd_data;

  function automatic word_t shift_in(input word_t cur, input byte_t b);
    if (BIG_ENDIAN) return {cur[23:0], b};
    else            return {b, cur[31:8]};
  endfunction

  // Errored bytes never reach the FIFO; clr drops the coincident strobe.
  assign w_wr_en = rx_valid & ~rx_ferr & ~clr & ~w_full;

  byte_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (clr),
    .wr_en   (w_wr_en),
    .wr_data (rx_data),
    .full    (w_full),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .empty   (w_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_overflow  <= 1'b0;
      r_ferr_seen <= 1'b0;
    end else if (clr) begin
      r_overflow  <= 1'b0;
      r_ferr_seen <= 1'b0;
    end else begin
      if (rx_valid & rx_ferr)           r_ferr_seen <= 1'b1;
      if (rx_valid & ~rx_ferr & w_full) r_overflow  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_FILL;
      r_cnt   <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_word  <= w_word_nxt;
    end
  end

  // A handshake in HOLD and the pop of the next byte share one edge, so a
  // continuous byte stream produces words with no bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_word_nxt  = r_word;
    w_pop       = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_word_nxt = shift_in(r_word, w_rd_data);
          if (r_cnt == LAST_IDX) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
      end
      ST_HOLD: begin
        if (word_ready) begin
          w_state_nxt = ST_FILL;
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_word_nxt = shift_in(r_word, w_rd_data);
            w_cnt_nxt  = 2'd1;
          end else begin
            w_cnt_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_FILL;
        w_cnt_nxt   = '0;
      end
    endcase
    if (clr) begin
      w_state_nxt = ST_FILL;
      w_cnt_nxt   = '0;
      w_word_nxt  = '0;
      w_pop       = 1'b0;
    end
  end

  assign word_data  = r_word;
  assign word_valid = (r_state == ST_HOLD);
  assign byte_cnt   = r_cnt;
  assign overflow   = r_overflow;
  assign ferr_seen  = r_ferr_seen;

endmodule

// File: tb/tb_uart_rx_word_buf.sv
module tb_uart_rx_word_buf;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ferr;
  logic        clr;
  logic        word_ready;
  logic [31:0] word_data;
  logic        word_valid;
  logic [4:0]  fifo_count;
  logic [1:0]  byte_cnt;
  logic        overflow;
  logic        ferr_seen;

  logic [31:0] le_word_data;
  logic        le_word_valid;
  logic [4:0]  le_fifo_count;
  logic [1:0]  le_byte_cnt;
  logic        le_overflow;
  logic        le_ferr_seen;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_word_buf #(.DEPTH_LOG2(4), .BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ferr(rx_ferr), .clr(clr), .word_data(word_data),
    .word_valid(word_valid), .word_ready(word_ready),
    .fifo_count(fifo_count), .byte_cnt(byte_cnt),
    .overflow(overflow), .ferr_seen(ferr_seen)
  );

  uart_rx_word_buf #(.DEPTH_LOG2(4), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ferr(rx_ferr), .clr(clr), .word_data(le_word_data),
    .word_valid(le_word_valid), .word_ready(word_ready),
    .fifo_count(le_fifo_count), .byte_cnt(le_byte_cnt),
    .overflow(le_overflow), .ferr_seen(le_ferr_seen)
  );

  // Scoreboard: every accepted word is compared with the oldest expected one.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rstn === 1'b1 && word_valid === 1'b1 && word_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL word_sb: got unexpected word %h, none expected", word_data);
      end else begin
        e = exp_q.pop_front();
        if (word_data !== e) begin
          n_fail++;
          $display("FAIL word_sb: got %h, expected %h", word_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_ferr = 1'b0;
    clr = 1'b0; word_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    n_checks++;
    if ({word_valid, overflow, ferr_seen} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, expected 000", {word_valid, overflow, ferr_seen});
    end
    n_checks++;
    if (word_data !== 32'h0 || fifo_count !== 5'd0 || byte_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: data=%h count=%0d bcnt=%0d, expected 0/0/0", word_data, fifo_count, byte_cnt);
    end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] w;
    w = 32'h12345678;
    word_ready = 1'b1;
    exp_q.push_back(w);
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1;
      rx_data  = w[31-8*i -: 8];
      tick();
    end
    rx_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early: word_valid=%b one cycle after 4th strobe, expected 0", word_valid);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (word_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_valid: word_valid=%b two cycles after 4th strobe, expected 1", word_valid);
    end
    n_checks++;
    if (le_word_valid !== 1'b1 || le_word_data !== 32'h78563412) begin
      n_fail++;
      $display("FAIL basic_le: valid=%b data=%h, expected 1 78563412", le_word_valid, le_word_data);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (word_valid !== 1'b0 || byte_cnt !== 2'd0 || fifo_count !== 5'd0) begin
      n_fail++;
      $display("FAIL basic_after: valid=%b bcnt=%0d count=%0d, expected 0/0/0", word_valid, byte_cnt, fifo_count);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_drain: %0d words outstanding, expected 0", exp_q.size());
    end
    tick();
  endtask

  // 21 strobes 0x00..0x14: four bytes sit in the held word, sixteen fill the
  // FIFO, and the 21st (0x14) is dropped.
  task automatic test_overflow();
    word_ready = 1'b0;
    for (int i = 0; i < 21; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(i);
      tick();
    end
    rx_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back({8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)});
    end
    @(negedge clk);
    n_checks++;
    if (word_valid !== 1'b1 || word_data !== 32'h00010203) begin
      n_fail++;
      $display("FAIL ovf_hold: valid=%b data=%h, expected 1 00010203", word_valid, word_data);
    end
    n_checks++;
    if (fifo_count !== 5'd16 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_full: count=%0d overflow=%b, expected 16 1", fifo_count, overflow);
    end
    tick();
    word_ready = 1'b1;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ovf_drain: %0d words outstanding, expected 0", exp_q.size());
    end
    tick(); tick();
    n_checks++;
    if (fifo_count !== 5'd0 || word_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_end: count=%0d valid=%b overflow=%b, expected 0 0 1", fifo_count, word_valid, overflow);
    end
  endtask

  task automatic test_clr();
    word_ready = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h61; tick();
    rx_data = 8'h62; tick();
    rx_valid = 1'b0; tick();
    n_checks++;
    if (byte_cnt !== 2'd2 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_pre: bcnt=%0d overflow=%b, expected 2 1", byte_cnt, overflow);
    end
    clr = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE;
    tick();
    clr = 1'b0; rx_valid = 1'b0;
    n_checks++;
    if (fifo_count !== 5'd0 || byte_cnt !== 2'd0 || word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_state: count=%0d bcnt=%0d valid=%b, expected 0 0 0", fifo_count, byte_cnt, word_valid);
    end
    n_checks++;
    if (overflow !== 1'b0 || ferr_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_flags: overflow=%b ferr=%b, expected 0 0", overflow, ferr_seen);
    end
    word_ready = 1'b1;
    exp_q.push_back(32'h21222324);
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(8'h21 + i);
      tick();
    end
    rx_valid = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL clr_drain: %0d words outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_ferr();
    logic [7:0] bytes [5];
    logic       errs  [5];
    bytes = '{8'h01, 8'h02, 8'hAA, 8'h03, 8'h04};
    errs  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    word_ready = 1'b1;
    exp_q.push_back(32'h01020304);
    for (int i = 0; i < 5; i++) begin
      rx_valid = 1'b1;
      rx_data  = bytes[i];
      rx_ferr  = errs[i];
      tick();
      if (i == 1) begin
        n_checks++;
        if (ferr_seen !== 1'b0) begin
          n_fail++;
          $display("FAIL ferr_pre: ferr_seen=%b, expected 0", ferr_seen);
        end
      end
      if (i == 2) begin
        n_checks++;
        if (ferr_seen !== 1'b1) begin
          n_fail++;
          $display("FAIL ferr_set: ferr_seen=%b, expected 1", ferr_seen);
        end
      end
    end
    rx_valid = 1'b0; rx_ferr = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    n_checks++;
    if (exp_q.size() != 0 || ferr_seen !== 1'b1 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ferr_end: outstanding=%0d ferr=%b overflow=%b, expected 0 1 0", exp_q.size(), ferr_seen, overflow);
    end
  endtask

  task automatic test_back_to_back();
    word_ready = 1'b0;
    exp_q.push_back(32'h31323334);
    for (int i = 0; i < 5; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(8'h31 + i);
      tick();
    end
    rx_valid = 1'b0;
    for (int c = 0; c < 10 && word_valid !== 1'b1; c++) tick();
    n_checks++;
    if (word_valid !== 1'b1 || fifo_count !== 5'd1) begin
      n_fail++;
      $display("FAIL b2b_hold: valid=%b count=%0d, expected 1 1", word_valid, fifo_count);
    end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    n_checks++;
    if (word_valid !== 1'b0 || byte_cnt !== 2'd1 || fifo_count !== 5'd0) begin
      n_fail++;
      $display("FAIL b2b_pop: valid=%b bcnt=%0d count=%0d, expected 0 1 0", word_valid, byte_cnt, fifo_count);
    end
    exp_q.push_back(32'h35363738);
    word_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(8'h36 + i);
      tick();
    end
    rx_valid = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: %0d words outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    word_ready = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h41; tick();
    rx_data = 8'h42; tick();
    rx_data = 8'h43;
    n_checks++;
    if (byte_cnt !== 2'd1 || ferr_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: bcnt=%0d ferr=%b, expected 1 1", byte_cnt, ferr_seen);
    end
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (word_data !== 32'h0 || fifo_count !== 5'd0 || byte_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL arst_state: data=%h count=%0d bcnt=%0d, expected 0 0 0", word_data, fifo_count, byte_cnt);
    end
    n_checks++;
    if ({word_valid, overflow, ferr_seen} !== 3'b000) begin
      n_fail++;
      $display("FAIL arst_flags: got %b, expected 000", {word_valid, overflow, ferr_seen});
    end
    rx_valid = 1'b0;
    tick(); tick();
    #2;
    rstn = 1'b1;
    tick();
    exp_q.delete();
    exp_q.push_back(32'h51525354);
    word_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(8'h51 + i);
      tick();
    end
    rx_valid = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL arst_drain: %0d words outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_clr();
    test_ferr();
    test_back_to_back();
    test_async_reset();
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
